// File: rtl/wide_ser_pkg.sv
// Shared types and helpers for the wide-word to byte-lane serializer.
package wide_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Zero or over-range lane counts mean "send the whole word".
  function automatic int sanitise_lanes(input int count, input int l);
    return (count == 0 || count > l) ? l : count;
  endfunction

endpackage

// File: rtl/wide_ser_hold.sv
// One-word holding register (data, lanes, frame flags) with a full flag.
// Written only when empty, drained only when full; one-cycle store.
module wide_ser_hold #(
  parameter int DW = 336,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [DW-1:0] i_data,
  input  logic [CW-1:0] i_lanes,
  input  logic          i_sof,
  input  logic          i_eof,
  output logic          o_full,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_lanes,
  output logic          o_sof,
  output logic          o_eof
);

  logic          r_full;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_lanes;
  logic          r_sof;
  logic          r_eof;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full  <= 1'b0;
      r_data  <= '0;
      r_lanes <= '0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (i_wr) begin
      r_full  <= 1'b1;
      r_data  <= i_data;
      r_lanes <= i_lanes;
      r_sof   <= i_sof;
      r_eof   <= i_eof;
    end else if (i_rd) begin
      r_full  <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_data  = r_data;
  assign o_lanes = r_lanes;
  assign o_sof   = r_sof;
  assign o_eof   = r_eof;

endmodule

// File: rtl/wide_byte_serializer.sv
// Wide word to OUT_W lane serializer, lowest lane first, lane 0 one cycle after accept;
// holds outputs under out_ready=0. WIDE_SER_PINGPONG_EN adds a holding register for zero-bubble words.
module wide_byte_serializer
  import wide_ser_pkg::*;
#(
  parameter  int IN_W  = 336,
  parameter  int OUT_W = 8,
  localparam int L     = IN_W / OUT_W,
  localparam int CNT_W = $clog2(L + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0] in_lanes,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_start,
  output logic             out_last,
  output logic             busy,
  output logic             err_lanes
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IN_W-1:0]  r_sreg;
  logic [CNT_W-1:0] r_left;
  logic             r_sof;
  logic             r_eof;
  logic             r_first;
  logic             r_err;

  logic             w_acc;
  logic             w_xfer;
  logic             w_final;
  logic             w_bad;
  logic             w_load_in;
  logic             w_load_hold;
  logic [CNT_W-1:0] w_lanes_san;
  logic             w_hold_full;
  logic [IN_W-1:0]  w_hold_data;
  logic [CNT_W-1:0] w_hold_lanes;
  logic             w_hold_sof;
  logic             w_hold_eof;

  assign out_valid   = (r_state == SHIFT);
  assign w_acc       = in_valid & in_ready;
  assign w_xfer      = out_valid & out_ready;
  assign w_final     = w_xfer & (r_left == CNT_W'(1));
  assign w_bad       = (in_lanes == '0) || (int'(in_lanes) > L);
  assign w_lanes_san = CNT_W'(sanitise_lanes(int'(in_lanes), L));

`ifdef WIDE_SER_PINGPONG_EN
  logic w_hold_wr;

  // Anything accepted that does not go straight into the shifter parks here.
  assign w_hold_wr = w_acc & ~w_load_in;
  assign in_ready  = ~w_hold_full;

  wide_ser_hold #(
    .DW (IN_W),
    .CW (CNT_W)
  ) u_hold (
    .clk     (clk),
    .rstn    (rstn),
    .i_wr    (w_hold_wr),
    .i_rd    (w_load_hold),
    .i_data  (in_data),
    .i_lanes (w_lanes_san),
    .i_sof   (in_sof),
    .i_eof   (in_eof),
    .o_full  (w_hold_full),
    .o_data  (w_hold_data),
    .o_lanes (w_hold_lanes),
    .o_sof   (w_hold_sof),
    .o_eof   (w_hold_eof)
  );
`else
  assign in_ready     = (r_state == IDLE);
  assign w_hold_full  = 1'b0;
  assign w_hold_data  = '0;
  assign w_hold_lanes = '0;
  assign w_hold_sof   = 1'b0;
  assign w_hold_eof   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_hold = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_load_in   = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_final) begin
          if (w_hold_full)  w_load_hold = 1'b1;
          else if (w_acc)   w_load_in   = 1'b1;
          else              w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sreg  <= '0;
      r_left  <= '0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_first <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_acc & w_bad;
      if (w_load_in) begin
        r_sreg  <= in_data;
        r_left  <= w_lanes_san;
        r_sof   <= in_sof;
        r_eof   <= in_eof;
        r_first <= 1'b1;
      end else if (w_load_hold) begin
        r_sreg  <= w_hold_data;
        r_left  <= w_hold_lanes;
        r_sof   <= w_hold_sof;
        r_eof   <= w_hold_eof;
        r_first <= 1'b1;
      end else if (w_xfer) begin
        r_sreg  <= r_sreg >> OUT_W;
        r_left  <= r_left - CNT_W'(1);
        r_first <= 1'b0;
      end
    end
  end

  assign out_data  = r_sreg[OUT_W-1:0];
  assign out_start = out_valid & r_sof & r_first;
  assign out_last  = out_valid & r_eof & (r_left == CNT_W'(1));
  assign busy      = out_valid | w_hold_full;
  assign err_lanes = r_err;

endmodule

// File: tb/tb_wide_byte_serializer.sv
// Bench: directed and random words on a 32-bit instance checked against a lane queue model,
// plus a default-width instance for the mid-word reset case.
module tb_wide_byte_serializer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_lanes = '0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_start, out_last, busy, err_lanes;
  logic [7:0]  out_data;

  logic         wd_in_valid = 1'b0;
  logic [335:0] wd_in_data = '0;
  logic [5:0]   wd_in_lanes = '0;
  logic         wd_in_sof = 1'b0;
  logic         wd_in_eof = 1'b0;
  logic         wd_in_ready, wd_out_valid, wd_out_start, wd_out_last, wd_busy, wd_err_lanes;
  logic [7:0]   wd_out_data;

  wide_byte_serializer #(.IN_W(32), .OUT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_lanes(in_lanes),
    .in_sof(in_sof), .in_eof(in_eof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_start(out_start), .out_last(out_last), .busy(busy), .err_lanes(err_lanes)
  );

  wide_byte_serializer dut_wide (
    .clk(clk), .rstn(rstn),
    .in_valid(wd_in_valid), .in_ready(wd_in_ready), .in_data(wd_in_data), .in_lanes(wd_in_lanes),
    .in_sof(wd_in_sof), .in_eof(wd_in_eof),
    .out_valid(wd_out_valid), .out_ready(out_ready), .out_data(wd_out_data),
    .out_start(wd_out_start), .out_last(wd_out_last), .busy(wd_busy), .err_lanes(wd_err_lanes)
  );

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   vhist[0:8191];
  bit   err_pred = 1'b0;
  bit   rnd_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Transfer scoreboard and err_lanes predictor for the 32-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (cyc < 8192) vhist[cyc] = out_valid;
    if (!rstn) begin
      err_pred = 1'b0;
    end else begin
      check("err_lanes", err_lanes, err_pred);
      err_pred = in_valid && in_ready && (in_lanes == 0 || in_lanes > 4);
      if (out_valid && out_ready) begin
        check("lane_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("lane_data", out_data, e.d);
          check("lane_start", out_start, e.s);
          check("lane_last", out_last, e.l);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick_rdy();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] n, input logic s, input logic e);
    int guard = 0;
    int nl;
    in_valid = 1'b1; in_data = d; in_lanes = n; in_sof = s; in_eof = e;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      tick_rdy();
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", in_ready, 1);
    acc_cyc = cyc;
    nl = (n == 0 || n > 4) ? 4 : int'(n);
    for (int k = 0; k < nl; k++)
      q.push_back(exp_t'{d[8*k +: 8], s && (k == 0), e && (k == nl - 1)});
    tick_rdy();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
      tick_rdy();
    end
    check("drain_queue", q.size(), 0);
    check("drain_idle", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0]  w;
    logic [335:0] wword;
    int           t0, ones, gaps, first, last;

    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_start", out_start, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_lanes, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_wide_valid", wd_out_valid, 0);
    check("rst_wide_in_ready", wd_in_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full word, no backpressure: lane k at T+1+k, in_ready back at T+5.
    w = 32'h44332211;
    send(w, 3'd4, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_valid0", out_valid, 1);
    check("t1_data0", out_data, 8'h11);
    check("t1_start0", out_start, 1);
    check("t1_busy", busy, 1);
`ifdef WIDE_SER_PINGPONG_EN
    check("t1_in_ready_busy", in_ready, 1);
`else
    check("t1_in_ready_busy", in_ready, 0);
`endif
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, w[8*k +: 8]);
      check("t1_start", out_start, 0);
      check("t1_last", out_last, k == 3);
    end
    @(negedge clk);
    check("t1_in_ready_t5", in_ready, 1);
    check("t1_idle_t5", out_valid, 0);
    check("t1_busy_t5", busy, 0);
    @(posedge clk); #1;

    // Backpressure during T+2..T+4 holds lane 1.
    send(w, 3'd4, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_data0", out_data, 8'h11);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_data", out_data, 8'h22);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Partial word and illegal lane counts.
    send(32'hDDCCBBAA, 3'd2, 1'b0, 1'b1);
    drain();
    send(32'hA1B2C3D4, 3'd0, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_err_l0", err_lanes, 1);
    drain();
    send(32'h0F1E2D3C, 3'd7, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_err_l7", err_lanes, 1);
    drain();

    // Two back-to-back words: gap between them depends on the build.
    send(32'h04030201, 3'd4, 1'b1, 1'b0);
    t0 = acc_cyc;
    send(32'h08070605, 3'd4, 1'b0, 1'b1);
    drain();
    ones = 0; gaps = 0; first = -1; last = -1;
    for (int i = t0 + 1; i <= t0 + 12; i++)
      if (vhist[i]) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
    for (int i = first; i <= last && first >= 0; i++)
      if (!vhist[i]) gaps++;
    check("pp_ones", ones, 8);
    check("pp_first", first, t0 + 1);
`ifdef WIDE_SER_PINGPONG_EN
    check("pp_gaps", gaps, 0);
`else
    check("pp_gaps", gaps, 1);
`endif

    // Random words with random backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++)
      send($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    rnd_rdy = 1'b0;
    out_ready = 1'b1;

    // Mid-word reset on the default-width instance.
    for (int i = 0; i < 42; i++) wword[8*i +: 8] = 8'($urandom_range(0, 255));
    wd_in_valid = 1'b1; wd_in_data = wword; wd_in_lanes = 6'd42; wd_in_sof = 1'b1; wd_in_eof = 1'b1;
    @(negedge clk);
    check("wd_in_ready", wd_in_ready, 1);
    @(posedge clk); #1;
    wd_in_valid = 1'b0;
    @(negedge clk);
    check("wd_data0", wd_out_data, wword[7:0]);
    check("wd_start0", wd_out_start, 1);
    @(negedge clk);
    check("wd_data1", wd_out_data, wword[15:8]);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("wd_rst_valid", wd_out_valid, 0);
    check("wd_rst_data", wd_out_data, 0);
    check("wd_rst_start", wd_out_start, 0);
    check("wd_rst_last", wd_out_last, 0);
    check("wd_rst_busy", wd_busy, 0);
    check("wd_rst_err", wd_err_lanes, 0);
    check("wd_rst_in_ready", wd_in_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("wd_post_idle", wd_out_valid, 0);
    for (int i = 0; i < 42; i++) wword[8*i +: 8] = 8'($urandom_range(0, 255));
    wd_in_valid = 1'b1; wd_in_data = wword; wd_in_lanes = 6'd3; wd_in_sof = 1'b0;
    @(posedge clk); #1;
    wd_in_valid = 1'b0;
    @(negedge clk);
    check("wd_new_valid", wd_out_valid, 1);
    check("wd_new_data0", wd_out_data, wword[7:0]);
    repeat (4) @(negedge clk);
    check("wd_new_done", wd_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wide_byte_serializer.md
# wide_byte_serializer

Parametrised wide-word to narrow-lane serializer with valid/ready handshakes on both sides, partial-word support and frame markers. It accepts an `IN_W`-bit word and emits it lane by lane, lowest lane first, producing the start/valid byte stream that feeds the PNG decoder (`hard_png` `istart`/`ivalid`/`ibyte`). It is the generalised successor of the fixed 336-to-8 shift buffer: it adds output backpressure, a per-word lane count, frame start/end flags and optional zero-bubble double buffering.

## Interface
- `IN_W`, 336, input word width; must be a multiple of `OUT_W`.
- `OUT_W`, 8, output lane width.
- `L` (localparam), `IN_W/OUT_W`, lanes per word.
- `CNT_W` (localparam), `$clog2(L+1)`, lane-count width.
- `clk  in  1`: rising-edge clock.
- `rstn  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`: input word offered.
- `in_ready  out  1`: block can accept a word; combinational from state.
- `in_data  in  IN_W`: word; lane k is `in_data[k*OUT_W +: OUT_W]`.
- `in_lanes  in  CNT_W`: number of valid lanes, 1..L.
- `in_sof  in  1`: word begins a frame.
- `in_eof  in  1`: word ends a frame.
- `out_valid  out  1`: `out_data` valid (maps to `ivalid`).
- `out_ready  in  1`: consumer accepts the lane.
- `out_data  out  OUT_W`: current lane (maps to `ibyte`).
- `out_start  out  1`: qualifies lane 0 of an `in_sof` word (maps to `istart`).
- `out_last  out  1`: qualifies the final lane of an `in_eof` word.
- `busy  out  1`: a word is held or being shifted.
- `err_lanes  out  1`: one-cycle pulse, illegal `in_lanes` seen.

## Operation
- Input transfer happens on a clock edge with `in_valid && in_ready`. Output transfer happens on a clock edge with `out_valid && out_ready`.
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - SHIFT: a word is loaded into the shift register and `lanes_left` counts down.
- IDLE→SHIFT on input accept.
  - The shift register loads `in_data`.
  - `lanes_left` loads the sanitised lane count.
  - The `sof`/`eof` flags are latched.
- In SHIFT, each output transfer shifts the register right by `OUT_W` and decrements `lanes_left`.
- On the transfer of the final lane (`lanes_left`==1), the next state is:
  - IDLE, when no next word is pending;
  - SHIFT with a new word (see Configuration), when one is pending.
- While `out_ready`=0, `out_valid`, `out_data`, `out_start` and `out_last` hold stable. There is no dropping and no reordering.
- `out_data` is always the low lane of the shift register. The lanes above `in_lanes` are never emitted.
- Lane-count sanitising: `in_lanes`==0 or `in_lanes`>L is treated as L, and `err_lanes` pulses in the cycle after the accept.
- `out_start` = `out_valid` && sof-flag && first lane of the word.
- `out_last` = `out_valid` && eof-flag && `lanes_left`==1.
- `busy` = (state != IDLE) or the holding register is full.

## Timing
- Reset (`rstn`=0, asynchronous):
  - state IDLE;
  - `out_valid`, `out_data`, `out_start`, `out_last`, `busy` and `err_lanes` are 0;
  - `in_ready`=1 (follows the reset state);
  - the holding register is empty.
- Reset mid-word discards all stored lanes. No partial output follows deassertion.
- Latency: a word accepted at edge T presents lane 0 with `out_valid`=1 from T+1.
- With `out_ready` held at 1, lane k is presented in cycle T+1+k.
- Without `WIDE_SER_PINGPONG_EN`, `in_ready`=0 from T+1 until the cycle after the final lane transfers. Throughput is n+1 cycles per n-lane word.

## Configuration
- Macro: `WIDE_SER_PINGPONG_EN`.
- Defined:
  - A one-word holding register (data, lanes, sof, eof) is added.
  - `in_ready` = holding register empty.
  - A word can be accepted while SHIFT is active.
  - On the final-lane transfer, a full holding register moves into the shift register on the same edge. `out_valid` stays 1, with zero bubble between words.
  - If the holding register is empty and the block is in IDLE, an input accept loads the shift register directly.
  - Simultaneous input accept and final-lane transfer with an empty holding register: the new word goes directly into the shift register.
- Undefined: single-buffer behaviour as described under Timing; there is no holding register.

## Structure
- Package `wide_ser_pkg` holds:
  - the `state_t` enum (IDLE, SHIFT);
  - the function `sanitise_lanes(count, L)`.
- Sub-module `wide_ser_hold`: the holding register with its full flag. It is instantiated only under `WIDE_SER_PINGPONG_EN`.

## Test plan
- IN_W=32, `in_data`=32'h44332211, `in_lanes`=4, sof=eof=1, `out_ready`=1:
  - bytes 11,22,33,44 appear in cycles T+1..T+4;
  - `out_start` is set with 11;
  - `out_last` is set with 44;
  - `in_ready`=1 at T+5.
- Same word with `out_ready` low during T+2..T+4: byte 22 is held stable for 3 cycles, and no byte is lost or duplicated.
- `in_lanes`=2, `in_data`=32'hDDCCBBAA, eof=1:
  - only AA and BB are emitted, with `out_last` on BB;
  - `err_lanes` stays 0.
- `in_lanes`=0 and, separately, `in_lanes`=7 (IN_W=32): `err_lanes` pulses at T+1 and all 4 lanes are emitted.
- `rstn` asserted after the second byte of a 42-lane default-width word: all outputs read 0 immediately, and after release the next word's lane 0 is the first output.
- With `WIDE_SER_PINGPONG_EN`, two back-to-back 4-lane words and `out_ready`=1 give 8 consecutive `out_valid` cycles with no gap. Without the macro, the same stimulus shows a one-cycle gap.
